// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port among PORT_COUNT single-word requesters.
// Define MEM_ARBITER_FIXED_PRIORITY_EN for lowest-port-first priority; default is round-robin.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int WORD_WIDTH = 64,
   parameter int PORT_COUNT = 2,
   parameter int PTR_BITS   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORT_COUNT*ADDR_WIDTH-1:0] addr,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] din,
   output logic [PORT_COUNT*WORD_WIDTH-1:0] dout,
   input  logic [PORT_COUNT-1:0]            re,
   input  logic [PORT_COUNT-1:0]            we,
   output logic [PORT_COUNT-1:0]            ready,
   output logic [PORT_COUNT-1:0]            grant,
   output logic [ADDR_WIDTH-1:0]            maddr,
   output logic [WORD_WIDTH-1:0]            mout,
   input  logic [WORD_WIDTH-1:0]            min,
   output logic                             mre,
   output logic                             mwe,
   input  logic                             mready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                          state, state_nxt;
   logic [PORT_COUNT-1:0]           req;
   logic                            any_req;
   logic                            complete;
   logic [PTR_BITS-1:0]             base;
   logic [PTR_BITS-1:0]             sel;
   logic                            op_rd, op_rd_d;
   logic [PORT_COUNT-1:0]           grant_d, ready_d;
   logic [ADDR_WIDTH-1:0]           maddr_d;
   logic [WORD_WIDTH-1:0]           mout_d;
   logic [PORT_COUNT*WORD_WIDTH-1:0] dout_d;
   logic                            mre_d, mwe_d;

   assign req      = re | we;
   assign any_req  = |req;
   assign complete = ((state == S_ISSUE) || (state == S_WAIT)) && mready;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
   // Scanning from PORT_COUNT-1 makes port 0 the first candidate every time.
   assign base = PTR_BITS'(PORT_COUNT - 1);
`else
   logic [PTR_BITS-1:0] last, cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= PTR_BITS'(PORT_COUNT - 1);
         cur  <= '0;
      end else begin
         if ((state == S_IDLE) && any_req)
            cur <= sel;
         if (complete)
            last <= cur;
      end
   end

   assign base = last;
`endif

   // Modulo scan starting just after base; PORT_COUNT need not be a power of two.
   always_comb begin : scan
      int   idx;
      logic found;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= PORT_COUNT; i++) begin
         idx = int'(base) + i;
         if (idx >= PORT_COUNT)
            idx = idx - PORT_COUNT;
         if (!found && req[idx]) begin
            sel   = PTR_BITS'(idx);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = mready ? S_DONE : S_WAIT;
         S_WAIT:  if (mready) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; everything not named here holds.
   always_comb begin
      grant_d = grant;
      maddr_d = maddr;
      mout_d  = mout;
      dout_d  = dout;
      op_rd_d = op_rd;
      ready_d = '0;
      mre_d   = 1'b0;
      mwe_d   = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               grant_d = PORT_COUNT'(1) << sel;
               maddr_d = addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
               mout_d  = din[int'(sel)*WORD_WIDTH +: WORD_WIDTH];
               op_rd_d = re[sel];
               mre_d   = re[sel];
               mwe_d   = ~re[sel];
            end
         end
         S_ISSUE, S_WAIT: begin
            if (mready) begin
               ready_d = grant;
               if (op_rd) begin
                  for (int p = 0; p < PORT_COUNT; p++)
                     if (grant[p])
                        dout_d[p*WORD_WIDTH +: WORD_WIDTH] = min;
               end
            end
         end
         default: grant_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant <= '0;
         ready <= '0;
         maddr <= '0;
         mout  <= '0;
         dout  <= '0;
         mre   <= 1'b0;
         mwe   <= 1'b0;
         op_rd <= 1'b0;
      end else begin
         grant <= grant_d;
         ready <= ready_d;
         maddr <= maddr_d;
         mout  <= mout_d;
         dout  <= dout_d;
         mre   <= mre_d;
         mwe   <= mwe_d;
         op_rd <= op_rd_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with three requesters: directed cases plus random traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

   localparam int N  = 3;
   localparam int AW = 64;
   localparam int WW = 64;
   localparam int PB = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] addr;
   logic [N*WW-1:0] din;
   logic [N*WW-1:0] dout;
   logic [N-1:0]    re, we, ready, grant;
   logic [AW-1:0]   maddr;
   logic [WW-1:0]   mout, min;
   logic            mre, mwe, mready;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PORT_COUNT(N), .PTR_BITS(PB)) dut (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .re(re), .we(we),
      .ready(ready), .grant(grant), .maddr(maddr), .mout(mout), .min(min),
      .mre(mre), .mwe(mwe), .mready(mready)
   );

   int n_chk = 0;
   int n_fail = 0;

   // requester state as driven by the bench
   bit            pend [N];
   bit            prd  [N];
   bit            pwr  [N];
   logic [AW-1:0] paddr[N];
   logic [WW-1:0] pdin [N];
   bit            hold_req;

   // transaction-level model of the arbiter
   int            phase;      // 0 eligible to grant, 1 transaction open, 2 dead cycle
   int            last;
   int            mport;
   bit            mrd;
   logic [AW-1:0] m_addr;
   logic [WW-1:0] m_din;
   logic [WW-1:0] dmodel[N];
   int            grant_log[$];
   int            nstrobe_rd = 0, nstrobe_wr = 0, nready = 0, cyc = 0;
   int            strobe_cyc, ready_cyc;
   logic [AW-1:0] strobe_maddr;
   logic [WW-1:0] strobe_mout;
   logic [N-1:0]  last_ready;

   // memory responder controls
   bit            mem_auto, rand_mem;
   int            mem_delay;
   logic [WW-1:0] mem_data;
   bit            rsp_pend, rsp_drv;
   int            rsp_cnt;

   task automatic chk(input string tag, input logic [N*WW-1:0] obs, input logic [N*WW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      int b, q;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
      b = N - 1;
`else
      b = last;
`endif
      for (int k = 1; k <= N; k++) begin
         q = (b + k) % N;
         if (pend[q]) return q;
      end
      return -1;
   endfunction

   function automatic logic [N*WW-1:0] dout_exp();
      logic [N*WW-1:0] v;
      for (int p = 0; p < N; p++) v[p*WW +: WW] = dmodel[p];
      return v;
   endfunction

   task automatic drive();
      for (int p = 0; p < N; p++) begin
         re[p] = pend[p] & prd[p];
         we[p] = pend[p] & pwr[p];
         addr[p*AW +: AW] = paddr[p];
         din[p*WW +: WW]  = pdin[p];
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < N; p++) begin
         pend[p] = 0; prd[p] = 0; pwr[p] = 0;
         paddr[p] = '0; pdin[p] = '0; dmodel[p] = '0;
      end
      phase = 0; last = N - 1; hold_req = 0;
   endtask

   task automatic set_req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [WW-1:0] d);
      pend[p] = 1; prd[p] = rd; pwr[p] = wr; paddr[p] = a; pdin[p] = d;
   endtask

   // One clock: observe just after the edge, compare with the model, then drive new requests.
   task automatic step(input bit rand_new);
      int sel, done_p, kind;
      logic [N-1:0] oh;
      @(posedge clk); #1;
      cyc++;
      done_p = -1;
      if (mre) nstrobe_rd++;
      if (mwe) nstrobe_wr++;
      oh = '0;
      case (phase)
         0: begin
            chk("idle_ready", ready, '0);
            sel = pick();
            if (sel >= 0) begin
               oh[sel] = 1'b1;
               chk("grant", grant, oh);
               chk("mre", mre, prd[sel]);
               chk("mwe", mwe, !prd[sel]);
               chk("maddr", maddr, paddr[sel]);
               chk("mout", mout, pdin[sel]);
               mport = sel; mrd = prd[sel]; m_addr = paddr[sel]; m_din = pdin[sel];
               grant_log.push_back(sel);
               strobe_cyc = cyc; strobe_maddr = maddr; strobe_mout = mout;
               if (rand_mem) begin
                  mem_delay = $urandom_range(0, 3);
                  mem_data  = {$urandom, $urandom};
               end
               phase = 1;
            end else
               chk("idle_quiet", {grant, mre, mwe}, '0);
         end
         1: begin
            oh[mport] = 1'b1;
            chk("busy_strobe", {mre, mwe}, '0);
            if (mready) begin
               if (mrd) dmodel[mport] = mem_data;
               chk("ready", ready, oh);
               chk("dout", dout, dout_exp());
               last = mport; nready++; last_ready = ready; ready_cyc = cyc;
               if (!hold_req) begin
                  pend[mport] = 0;
                  done_p = mport;
               end
               phase = 2;
            end else begin
               chk("busy_ready", ready, '0);
               chk("busy_grant", grant, oh);
               chk("busy_maddr", maddr, m_addr);
               chk("busy_mout", mout, m_din);
            end
         end
         default: begin
            chk("dead_ready", ready, '0);
            chk("dead_grant", grant, '0);
            chk("dead_strobe", {mre, mwe}, '0);
            phase = 0;
         end
      endcase
      if (rand_new) begin
         for (int p = 0; p < N; p++) begin
            if (!pend[p] && p != done_p && $urandom_range(0, 2) == 0) begin
               kind = $urandom_range(0, 2);
               set_req(p, kind != 1, kind != 0, {$urandom, $urandom}, {$urandom, $urandom});
            end
         end
      end
      drive();
   endtask

   task automatic run_until(input int target, input int budget, input bit rand_new, input string tag);
      int k;
      k = 0;
      while (nready < target && k < budget) begin
         step(rand_new);
         k++;
      end
      chk(tag, nready >= target, 1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      drive();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, grant, '0);
      chk({tag, "_ready"}, ready, '0);
      chk({tag, "_strobe"}, {mre, mwe}, '0);
      chk({tag, "_maddr"}, maddr, '0);
      chk({tag, "_mout"}, mout, '0);
      chk({tag, "_dout"}, dout, '0);
   endtask

   // Downstream memory: answers each strobe after mem_delay cycles with a one-cycle mready.
   initial begin
      mready = 1'b0; min = '0; rsp_pend = 0; rsp_drv = 0; rsp_cnt = 0;
      forever begin
         @(posedge clk); #2;
         if (rsp_drv) begin
            mready = 1'b0;
            rsp_drv = 0;
         end
         if (!mready) min = {$urandom, $urandom};
         if (mem_auto && (mre || mwe)) begin
            rsp_pend = 1;
            rsp_cnt = mem_delay;
         end
         if (rsp_pend) begin
            if (rsp_cnt == 0) begin
               mready = 1'b1; rsp_drv = 1; min = mem_data; rsp_pend = 0;
            end else
               rsp_cnt--;
         end
      end
   end

   initial begin
      int s_rd, s_wr, g0, r0, k, got;
      int fair_exp[6];
      rst = 1'b1; re = '0; we = '0; addr = '0; din = '0;
      mem_auto = 1; rand_mem = 0; mem_delay = 0; mem_data = '0;
      model_reset();
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("rst");
      rst = 1'b0;

      // single read on port 1, memory answers after three cycles
      set_req(1, 1, 0, 64'h100, 64'h5555);
      mem_delay = 3; mem_data = 64'hDEAD;
      drive();
      s_rd = nstrobe_rd; s_wr = nstrobe_wr;
      run_until(nready + 1, 30, 0, "rd_done");
      chk("rd_mre_pulses", nstrobe_rd - s_rd, 1);
      chk("rd_mwe_pulses", nstrobe_wr - s_wr, 0);
      chk("rd_maddr", strobe_maddr, 64'h100);
      chk("rd_ready", last_ready, 3'b010);
      chk("rd_dout1", dout[WW +: WW], 64'hDEAD);
      chk("rd_latency", ready_cyc - strobe_cyc, 4);

      // write on port 0
      set_req(0, 0, 1, 64'h40, 64'h1234);
      mem_delay = 1; mem_data = 64'hFFFF;
      drive();
      s_rd = nstrobe_rd; s_wr = nstrobe_wr;
      run_until(nready + 1, 30, 0, "wr_done");
      chk("wr_mwe_pulses", nstrobe_wr - s_wr, 1);
      chk("wr_mre_pulses", nstrobe_rd - s_rd, 0);
      chk("wr_maddr", strobe_maddr, 64'h40);
      chk("wr_mout", strobe_mout, 64'h1234);
      chk("wr_ready", last_ready, 3'b001);
      chk("wr_dout0_hold", dout[0 +: WW], '0);

      // zero-wait memory on port 2
      set_req(2, 1, 0, 64'h880, 64'h0);
      mem_delay = 0; mem_data = 64'hBEEF;
      drive();
      run_until(nready + 1, 30, 0, "zw_done");
      chk("zw_latency", ready_cyc - strobe_cyc, 1);
      chk("zw_ready", last_ready, 3'b100);
      chk("zw_dout2", dout[2*WW +: WW], 64'hBEEF);
      chk("zw_dout1_hold", dout[WW +: WW], 64'hDEAD);

      // fairness: ports 0 and 1 hold re through six transactions
      do_reset();
      rand_mem = 1; hold_req = 1;
      set_req(0, 1, 0, 64'h1000, 64'h0);
      set_req(1, 1, 0, 64'h2000, 64'h0);
      drive();
      g0 = grant_log.size();
      run_until(nready + 6, 200, 0, "fair_done");
      hold_req = 0;
      for (int p = 0; p < N; p++) pend[p] = 0;
      drive();
      for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
         fair_exp[i] = 0;
`else
         fair_exp[i] = i % 2;
`endif
         got = (g0 + i < grant_log.size()) ? grant_log[g0 + i] : -1;
         chk($sformatf("fair_order%0d", i), got, fair_exp[i]);
      end
      repeat (3) step(0);

      // port 0 asserts re and we together while port 2 waits with a write
      do_reset();
      set_req(0, 1, 1, 64'h300, 64'hAAAA);
      set_req(2, 0, 1, 64'h500, 64'hBBBB);
      drive();
      g0 = grant_log.size();
      s_rd = nstrobe_rd; s_wr = nstrobe_wr;
      run_until(nready + 2, 60, 0, "rw_done");
      got = (g0 < grant_log.size()) ? grant_log[g0] : -1;
      chk("rw_first", got, 0);
      got = (g0 + 1 < grant_log.size()) ? grant_log[g0 + 1] : -1;
      chk("rw_second", got, 2);
      chk("rw_mre_pulses", nstrobe_rd - s_rd, 1);
      chk("rw_mwe_pulses", nstrobe_wr - s_wr, 1);

      // random traffic, then drain
      r0 = nready;
      repeat (400) step(1);
      k = 0;
      while ((pend[0] || pend[1] || pend[2] || phase != 0) && k < 200) begin
         step(0);
         k++;
      end
      chk("rand_drained", k < 200, 1'b1);
      chk("rand_progress", (nready - r0) > 10, 1'b1);

      // asynchronous reset in the middle of a waiting read
      do_reset();
      mem_auto = 0; rand_mem = 0;
      set_req(1, 1, 0, 64'h200, 64'h0);
      drive();
      k = 0;
      while (phase != 1 && k < 10) begin
         step(0);
         k++;
      end
      chk("abort_granted", phase, 1);
      repeat (2) step(0);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("abort");
      model_reset();
      drive();
      @(posedge clk); #1;
      rst = 1'b0;
      step(0);
      min = 64'hBAD; mready = 1'b1;
      step(0);
      mready = 1'b0;
      repeat (3) step(0);
      chk("abort_dout", dout, '0);
      mem_auto = 1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
